// File: rtl/sbox_round_ctrl_pkg.sv
// Shared types and widths for the substitution round sequencer.
package sbox_ctrl_pkg;

   localparam int BLK_W   = 128;
   localparam int SEED_W  = 256;
   localparam int ROUND_W = 32;
   localparam int CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sbox_round_ctrl_if.sv
// Block input, datapath drive/return and result output of the round sequencer.
// The slave view belongs to the sequencer; the master view to its surroundings.
interface sbox_round_ctrl_if;
   import sbox_ctrl_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [BLK_W-1:0]     in_data;
   logic [SEED_W-1:0]    in_seed;
   logic [BLK_W-1:0]     sub_a;
   logic [SEED_W-1:0]    sub_seed;
   logic [ROUND_W-1:0]   sub_round_num;
   logic [BLK_W-1:0]     sub_c;
   logic                 out_valid;
   logic                 out_ready;
   logic [BLK_W-1:0]     out_data;

   modport slave (
      input  in_valid, in_data, in_seed, sub_c, out_ready,
      output in_ready, sub_a, sub_seed, sub_round_num, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, in_seed, sub_c, out_ready,
      input  in_ready, sub_a, sub_seed, sub_round_num, out_valid, out_data
   );

endinterface

// File: rtl/sbox_round_ctrl.sv
// Round sequencer for the keyed substitution stage. Loads one block and seed,
// holds them stable towards the external PRNG/XOR datapath for SUB_LAT cycles
// per round, captures the result, and presents the final state on out_*.
// Optional macro SBOX_CTRL_ABORT_EN adds an 'abort' input that drops the
// block in flight.
module sbox_round_ctrl
   import sbox_ctrl_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 14,
   parameter int unsigned SUB_LAT    = 1,
   parameter int unsigned ROUND_BASE = 1
) (
   input  logic               clk,
   input  logic               rst,
`ifdef SBOX_CTRL_ABORT_EN
   input  logic               abort,
`endif
   sbox_round_ctrl_if.slave   bus,
   output logic               busy,
   output logic [CNT_W-1:0]   blk_count
);

   localparam int unsigned     WAIT_W     = (SUB_LAT > 1) ? $clog2(SUB_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SUB_LAT - 1);
   localparam logic [63:0]     LAST_WIDE  = 64'(ROUND_BASE) + 64'(NUM_ROUNDS) - 64'd1;
   localparam logic [ROUND_W-1:0] FIRST_ROUND = ROUND_W'(ROUND_BASE);
   localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(LAST_WIDE);

   // The last round number must fit the 32-bit round register.
   if (NUM_ROUNDS < 1 || SUB_LAT < 1 || LAST_WIDE > 64'h0000_0000_FFFF_FFFF) begin : g_bad_params
      $error("sbox_round_ctrl: illegal NUM_ROUNDS/SUB_LAT/ROUND_BASE");
   end

   logic abort_i;
`ifdef SBOX_CTRL_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   state_t               state, state_nxt;
   logic [BLK_W-1:0]     state_reg;
   logic [SEED_W-1:0]    seed_reg;
   logic [ROUND_W-1:0]   round;
   logic [WAIT_W-1:0]    wait_cnt;
   logic                 load, capture, last_round;

   assign load       = (state == IDLE) && bus.in_valid;
   assign capture    = (state == RUN) && !abort_i && (wait_cnt == WAIT_LAST);
   assign last_round = (round == LAST_ROUND);

   assign bus.sub_a         = state_reg;
   assign bus.sub_seed      = seed_reg;
   assign bus.sub_round_num = round;
   assign bus.out_data      = state_reg;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decision: abort wins over round completion and output handshake
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)                state_nxt = RUN;
         RUN:     if (abort_i)                     state_nxt = IDLE;
                  else if (capture && last_round)  state_nxt = DONE;
         DONE:    if (abort_i || bus.out_ready)    state_nxt = IDLE;
         default:                                  state_nxt = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state
   always_comb begin
      bus.in_ready  = (state == IDLE);
      busy          = (state != IDLE);
      bus.out_valid = (state == DONE);
   end

   // Working state, seed, round number and per-round wait counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= '0;
         seed_reg  <= '0;
         round     <= '0;
         wait_cnt  <= '0;
      end else if (load) begin
         state_reg <= bus.in_data;
         seed_reg  <= bus.in_seed;
         round     <= FIRST_ROUND;
         wait_cnt  <= '0;
      end else if (state == RUN && !abort_i) begin
         if (capture) begin
            state_reg <= bus.sub_c;
            wait_cnt  <= '0;
            if (!last_round) round <= round + ROUND_W'(1);
         end else begin
            wait_cnt  <= wait_cnt + WAIT_W'(1);
         end
      end
   end

   // Completed output transfers; a transfer coinciding with abort still counts
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  blk_count <= '0;
      else if (state == DONE && bus.out_ready)  blk_count <= blk_count + CNT_W'(1);
   end

endmodule
